// File: rtl/rv32m_muldiv_if.sv
// Operand/request and write-back bundle between decode/register heap and the RV32M unit.
interface rv32m_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd;
    logic            busy;
    logic            done;
    logic            wb_en;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;

    modport master (
        output start, funct3, rs1_val, rs2_val, rd,
        input  busy, done, wb_en, wb_addr, wb_data
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val, rd,
        output busy, done, wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, sign fix-up in a single FIX cycle, one-cycle write-back request.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// CALC  | XLEN iterations, one product/quotient bit per cycle
// FIX   | sign correction, result select, special cases; wb_data/wb_addr registered
// DONE  | done (and wb_en when rd != 0) for one cycle
module rv32m_muldiv #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    rv32m_muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   m;
    logic [XLEN-1:0]   hi, lo;
    logic              neg_q, neg_r, div_zero;
    logic              busy_q, done_q, wb_en_q;
    logic [4:0]        wb_addr_q;
    logic [XLEN-1:0]   wb_data_q;

    logic              a_sgn, b_sgn;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic              ge;
    logic [XLEN-1:0]   trial;
    logic [XLEN-1:0]   hi_n, lo_n;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (bus.start) state_nx = S_CALC;
            S_CALC: if (cnt == '0) state_nx = S_FIX;
            S_FIX:  state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Signedness of each operand follows funct3: rs1 signed for MULH/MULHSU/DIV/REM,
    // rs2 signed for MULH/DIV/REM.
    always_comb begin
        a_sgn = ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                 (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) && bus.rs1_val[XLEN-1];
        b_sgn = ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                 (bus.funct3 == 3'b110)) && bus.rs2_val[XLEN-1];
        a_abs = a_sgn ? -bus.rs1_val : bus.rs1_val;
        b_abs = b_sgn ? -bus.rs2_val : bus.rs2_val;
    end

    // One iteration: {hi,lo} is the product (multiplier shifts out of lo) for multiply,
    // and {remainder,quotient/dividend} for divide; m is multiplicand or divisor.
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        rem_sh  = {hi, lo[XLEN-1]};
        ge      = (rem_sh >= {1'b0, m});
        trial   = rem_sh[XLEN-1:0] - m;
        if (op[2]) begin
            hi_n = ge ? trial : rem_sh[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], ge};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // A zero divisor leaves remainder = |rs1|, which the dividend sign restores to rs1;
    // only the quotient needs forcing. The signed-overflow case falls out naturally.
    always_comb begin
        prod_s = neg_q ? -{hi, lo} : {hi, lo};
        quo_s  = div_zero ? '1 : (neg_q ? -lo : lo);
        rem_s  = neg_r ? -hi : hi;
        if (op[2])               result = op[1] ? rem_s : quo_s;
        else if (op[1:0] == 2'b00) result = prod_s[XLEN-1:0];
        else                     result = prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            op        <= '0;
            rd_q      <= '0;
            m         <= '0;
            hi        <= '0;
            lo        <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            busy_q  <= (state_nx == S_CALC) || (state_nx == S_FIX);
            done_q  <= (state_nx == S_DONE);
            wb_en_q <= (state_nx == S_DONE) && (rd_q != 5'd0);
            case (state)
                S_IDLE: if (bus.start) begin
                    op       <= bus.funct3;
                    rd_q     <= bus.rd;
                    cnt      <= CW'(XLEN - 1);
                    neg_q    <= a_sgn ^ b_sgn;
                    neg_r    <= a_sgn;
                    div_zero <= (bus.rs2_val == '0);
                    hi       <= '0;
                    m        <= bus.funct3[2] ? b_abs : a_abs;
                    lo       <= bus.funct3[2] ? a_abs : b_abs;
                end
                S_CALC: begin
                    hi <= hi_n;
                    lo <= lo_n;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                S_FIX: begin
                    wb_data_q <= result;
                    wb_addr_q <= rd_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.wb_en   = wb_en_q;
    assign bus.wb_addr = wb_addr_q;
    assign bus.wb_data = wb_data_q;
endmodule
